// File: rtl/label_window.sv
// ---------------------------------------------------------------------------
// label_window
//   Raster-scan neighbourhood former for a connected-component labeler.
//   Accepts one binarized pixel at a time and issues the pixel together with
//   the labels of its already-labeled neighbours:
//       A B C      A = up-left, B = up, C = up-right (previous row)
//       D p        D = left (current row), p = current pixel
//   It then waits for the labeling stage to return the resolved label of
//   that pixel before it accepts the next one. Labels returned for the
//   current row overwrite the one-row line buffer in place, so the buffer
//   always holds "previous row" labels for columns not yet visited.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   in_valid/in_ready   pixel handshake (in_ready = 1 only in S_IDLE)
//   in_pixel, in_sof    pixel value (nonzero = foreground), start of frame
//   out_valid           one-cycle strobe; A,B,C,D,p,x,y valid with it
//   A,B,C,D,p           neighbourhood labels and the current pixel
//   x, y                coordinates of the issued pixel
//   lbl_valid, lbl      label returned for the outstanding pixel
//   frame_done          one-cycle pulse after the last label of a frame
//   lbl_err             sticky: lbl_valid seen with no pixel outstanding
// ---------------------------------------------------------------------------
module label_window #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_pixel,
  input  logic                 in_sof,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] A,
  output logic [WORD_SIZE-1:0] B,
  output logic [WORD_SIZE-1:0] C,
  output logic [WORD_SIZE-1:0] D,
  output logic [WORD_SIZE-1:0] p,
  output logic [15:0]          x,
  output logic [15:0]          y,
  input  logic                 lbl_valid,
  input  logic [WORD_SIZE-1:0] lbl,
  output logic                 frame_done,
  output logic                 lbl_err
);

  localparam int          AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                 state_q;
  logic [15:0]            x_cur_q, y_cur_q;   // position of next / outstanding pixel
  logic [15:0]            x_cur_d, y_cur_d;   // position after a write-back
  logic [WORD_SIZE-1:0]   a_hist_q;           // B issued for the previous column
  logic [WORD_SIZE-1:0]   d_hist_q;           // label written for the previous column
  logic                   out_valid_q, frame_done_q, lbl_err_q;
  logic [WORD_SIZE-1:0]   a_q, b_q, c_q, d_q, p_q;
  logic [15:0]            x_q, y_q;

  // One row of labels; intentionally not reset. Row 0 never reads it
  // (A/B/C forced to 0), so stale contents after reset are harmless.
  logic [WORD_SIZE-1:0]   line_buf [IMG_W];

  // Handshake qualifiers
  logic accept, wb, wb_last_col, wb_last_row;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign wb     = (state_q == S_WAIT) && lbl_valid;

  // Position of the pixel being accepted: a start-of-frame pixel is always
  // (0,0) whatever the counters say.
  logic [15:0]   pos_x, pos_y;
  logic          row0, col0, col_last;
  logic [AW-1:0] b_idx, c_idx;

  assign pos_x    = in_sof ? 16'd0 : x_cur_q;
  assign pos_y    = in_sof ? 16'd0 : y_cur_q;
  assign row0     = (pos_y == 16'd0);
  assign col0     = (pos_x == 16'd0);
  assign col_last = (pos_x == X_LAST);
  assign b_idx    = pos_x[AW-1:0];
  // Clamp the up-right index on the last column so the read stays in range;
  // the value is masked to 0 there anyway.
  assign c_idx    = col_last ? b_idx : b_idx + AW'(1);

  // Neighbourhood as seen at accept time. Line buffer entries at b_idx and
  // c_idx still hold the previous row because this row's labels for those
  // columns have not been written back yet.
  logic [WORD_SIZE-1:0] a_nb, b_nb, c_nb, d_nb;

  assign b_nb = row0             ? '0 : line_buf[b_idx];
  assign c_nb = (row0 || col_last) ? '0 : line_buf[c_idx];
  assign a_nb = (row0 || col0)   ? '0 : a_hist_q;
  assign d_nb = col0             ? '0 : d_hist_q;

  // Raster counter advance on write-back
  assign wb_last_col = (x_cur_q == X_LAST);
  assign wb_last_row = (y_cur_q == Y_LAST);

  always_comb begin
    x_cur_d = x_cur_q + 16'd1;
    y_cur_d = y_cur_q;
    if (wb_last_col) begin
      x_cur_d = 16'd0;
      y_cur_d = wb_last_row ? 16'd0 : y_cur_q + 16'd1;
    end
  end

  // Control, counters, history and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_cur_q      <= '0;
      y_cur_q      <= '0;
      a_hist_q     <= '0;
      d_hist_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      lbl_err_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      p_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;

      // A label with nothing outstanding is flagged and otherwise dropped.
      if (lbl_valid && (state_q == S_IDLE))
        lbl_err_q <= 1'b1;

      if (state_q == S_IDLE) begin
        if (accept) begin
          a_q         <= a_nb;
          b_q         <= b_nb;
          c_q         <= c_nb;
          d_q         <= d_nb;
          p_q         <= in_pixel;
          x_q         <= pos_x;
          y_q         <= pos_y;
          // Counters now name the outstanding pixel (matters after in_sof).
          x_cur_q     <= pos_x;
          y_cur_q     <= pos_y;
          // This column's B becomes the next column's A.
          a_hist_q    <= b_nb;
          out_valid_q <= 1'b1;
          state_q     <= S_WAIT;
        end
      end else begin
        // in_valid is ignored here; a pixel held across the write-back is
        // taken on the following cycle from S_IDLE.
        if (wb) begin
          d_hist_q     <= lbl;
          x_cur_q      <= x_cur_d;
          y_cur_q      <= y_cur_d;
          frame_done_q <= wb_last_col && wb_last_row;
          state_q      <= S_IDLE;
        end
      end
    end
  end

  // Line buffer write port: only the returned label of the outstanding pixel.
  always_ff @(posedge clk) begin
    if (wb)
      line_buf[x_cur_q[AW-1:0]] <= lbl;
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign A          = a_q;
  assign B          = b_q;
  assign C          = c_q;
  assign D          = d_q;
  assign p          = p_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = frame_done_q;
  assign lbl_err    = lbl_err_q;

endmodule

// File: tb/tb_label_window.sv
// ---------------------------------------------------------------------------
// tb_label_window
//   Bench for label_window with IMG_W=4, IMG_H=2, WORD_SIZE=8.
//   A table of pixels / returned labels with hand-derived neighbourhoods
//   drives two frames; expected windows go into a queue when a pixel is
//   driven and are popped when out_valid is seen. Hand-written sequences
//   cover the stray label, simultaneous pixel/write-back, mid-row reset and
//   start-of-frame cases.
// ---------------------------------------------------------------------------
module tb_label_window;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sof, lbl_valid;
  logic [7:0]  in_pixel, lbl;
  logic        in_ready, out_valid, frame_done, lbl_err;
  logic [7:0]  A, B, C, D, p;
  logic [15:0] x, y;

  label_window #(.IMG_W(4), .IMG_H(2), .WORD_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .A(A), .B(B), .C(C), .D(D), .p(p), .x(x), .y(y),
    .lbl_valid(lbl_valid), .lbl(lbl), .frame_done(frame_done), .lbl_err(lbl_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [71:0] exp_q [$];
  logic [71:0] mon_e;

  typedef struct {
    logic [7:0]  pix;
    logic        sof;
    logic [7:0]  lb;
    logic [7:0]  ea, eb, ec, ed;
    logic [15:0] ex, ey;
    logic        efd;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [71:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d,
                                     input logic [7:0] pp, input logic [15:0] xx,
                                     input logic [15:0] yy);
    return {a, b, c, d, pp, xx, yy};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Scoreboard: every out_valid strobe must match the oldest pending window.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got window %h expected none",
                 {A, B, C, D, p, x, y});
      end else begin
        mon_e = exp_q.pop_front();
        chk("issued_window", {A, B, C, D, p, x, y}, mon_e);
      end
    end
  end

  // Drive one pixel; expects it to be accepted on the next edge.
  task automatic do_pixel(input logic [7:0] pix, input logic sof, input logic [71:0] e);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_accept", 72'(in_ready), 72'(1));
    in_pixel = pix;
    in_sof   = sof;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("out_valid_next_cycle", 72'(out_valid), 72'(1));
    chk("in_ready_low_waiting", 72'(in_ready), 72'(0));
    chk("frame_done_idle", 72'(frame_done), 72'(0));
  endtask

  // Return a label after a two-cycle labeling latency.
  task automatic do_lbl(input logic [7:0] l, input logic fd);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("out_valid_one_cycle", 72'(out_valid), 72'(0));
    chk("in_ready_still_low", 72'(in_ready), 72'(0));
    lbl       = l;
    lbl_valid = 1'b1;
    @(posedge clk); #1;
    lbl_valid = 1'b0;
    chk("in_ready_after_wb", 72'(in_ready), 72'(1));
    chk("frame_done_pulse", 72'(frame_done), 72'(fd));
  endtask

  task automatic stray_lbl(input logic [7:0] l);
    lbl       = l;
    lbl_valid = 1'b1;
    @(posedge clk); #1;
    lbl_valid = 1'b0;
    chk("lbl_err_set", 72'(lbl_err), 72'(1));
    chk("stray_no_issue", 72'(out_valid), 72'(0));
    chk("stray_stays_idle", 72'(in_ready), 72'(1));
    @(posedge clk); #1;
    chk("lbl_err_sticky", 72'(lbl_err), 72'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           pix    sof   lbl    A      B      C      D      x       y       fd
    tbl[0]  = '{8'h01, 1'b0, 8'd1,  8'd0,  8'd0,  8'd0,  8'd0,  16'd0, 16'd0, 1'b0};
    tbl[1]  = '{8'h05, 1'b0, 8'd1,  8'd0,  8'd0,  8'd0,  8'd1,  16'd1, 16'd0, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 8'd2,  8'd0,  8'd0,  8'd0,  8'd1,  16'd2, 16'd0, 1'b0};
    tbl[3]  = '{8'hFF, 1'b0, 8'd2,  8'd0,  8'd0,  8'd0,  8'd2,  16'd3, 16'd0, 1'b0};
    tbl[4]  = '{8'h11, 1'b0, 8'd3,  8'd0,  8'd1,  8'd1,  8'd0,  16'd0, 16'd1, 1'b0};
    tbl[5]  = '{8'h22, 1'b0, 8'd4,  8'd1,  8'd1,  8'd2,  8'd3,  16'd1, 16'd1, 1'b0};
    tbl[6]  = '{8'h33, 1'b0, 8'd5,  8'd1,  8'd2,  8'd2,  8'd4,  16'd2, 16'd1, 1'b0};
    tbl[7]  = '{8'h44, 1'b0, 8'd6,  8'd2,  8'd2,  8'd0,  8'd5,  16'd3, 16'd1, 1'b1};
    tbl[8]  = '{8'h55, 1'b0, 8'd7,  8'd0,  8'd0,  8'd0,  8'd0,  16'd0, 16'd0, 1'b0};
    tbl[9]  = '{8'h66, 1'b0, 8'd8,  8'd0,  8'd0,  8'd0,  8'd7,  16'd1, 16'd0, 1'b0};
    tbl[10] = '{8'h77, 1'b0, 8'd9,  8'd0,  8'd0,  8'd0,  8'd8,  16'd2, 16'd0, 1'b0};
    tbl[11] = '{8'h88, 1'b0, 8'd10, 8'd0,  8'd0,  8'd0,  8'd9,  16'd3, 16'd0, 1'b0};
    tbl[12] = '{8'h99, 1'b0, 8'd11, 8'd0,  8'd7,  8'd8,  8'd0,  16'd0, 16'd1, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = 8'h00;
    lbl_valid = 1'b0;
    lbl       = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_window", {A, B, C, D, p, x, y}, 72'(0));
    chk("reset_out_valid", 72'(out_valid), 72'(0));
    chk("reset_in_ready", 72'(in_ready), 72'(1));
    chk("reset_frame_done", 72'(frame_done), 72'(0));
    chk("reset_lbl_err", 72'(lbl_err), 72'(0));

    // Two frames' worth of raster pixels and labels.
    for (int i = 0; i < 13; i++) begin
      do_pixel(tbl[i].pix, tbl[i].sof,
               pk(tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed, tbl[i].pix, tbl[i].ex, tbl[i].ey));
      do_lbl(tbl[i].lb, tbl[i].efd);
    end

    // Stray label in S_IDLE at (1,1): no write, no counter or D change.
    stray_lbl(8'd99);
    do_pixel(8'hAA, 1'b0, pk(8'd7, 8'd8, 8'd9, 8'd11, 8'hAA, 16'd1, 16'd1));

    // Pixel held valid through the write-back: only the write-back happens,
    // the pixel is issued one cycle later.
    @(posedge clk); #1;
    in_pixel  = 8'hBB;
    in_valid  = 1'b1;
    lbl       = 8'd12;
    lbl_valid = 1'b1;
    exp_q.push_back(pk(8'd8, 8'd9, 8'd10, 8'd12, 8'hBB, 16'd2, 16'd1));
    @(posedge clk); #1;
    lbl_valid = 1'b0;
    chk("simul_no_issue", 72'(out_valid), 72'(0));
    chk("simul_idle", 72'(in_ready), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("simul_issue_next", 72'(out_valid), 72'(1));
    chk("simul_wait", 72'(in_ready), 72'(0));
    do_lbl(8'd13, 1'b0);

    // Reset while a pixel is outstanding.
    do_pixel(8'hCC, 1'b0, pk(8'd9, 8'd10, 8'd0, 8'd13, 8'hCC, 16'd3, 16'd1));
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrow_reset_window", {A, B, C, D, p, x, y}, 72'(0));
    chk("midrow_reset_out_valid", 72'(out_valid), 72'(0));
    chk("midrow_reset_in_ready", 72'(in_ready), 72'(1));
    chk("midrow_reset_lbl_err", 72'(lbl_err), 72'(0));
    stray_lbl(8'd50);
    do_pixel(8'hDD, 1'b0, pk(8'd0, 8'd0, 8'd0, 8'd0, 8'hDD, 16'd0, 16'd0));
    do_lbl(8'd20, 1'b0);
    do_pixel(8'hEE, 1'b0, pk(8'd0, 8'd0, 8'd0, 8'd20, 8'hEE, 16'd1, 16'd0));
    do_lbl(8'd21, 1'b0);

    // Start of frame overrides the counters at x=2.
    do_pixel(8'hF0, 1'b1, pk(8'd0, 8'd0, 8'd0, 8'd0, 8'hF0, 16'd0, 16'd0));
    do_lbl(8'd22, 1'b0);
    do_pixel(8'hF1, 1'b0, pk(8'd0, 8'd0, 8'd0, 8'd22, 8'hF1, 16'd1, 16'd0));
    do_lbl(8'd23, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 72'(exp_q.size()), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
